debug_trace_buffer: RTL and testbench
=====================================

DEBUG_TRACE_BUFFER -- requirements
Module: debug_trace_buffer

Interface
REQ-001 SHALL provide parameter DATA_W, default 16, sample width in bits.
REQ-002 SHALL provide parameter DEPTH, default 64, entry count; power of two, at least 4.
REQ-003 SHALL provide parameter PRE_TRIG, default 16, minimum pre-trigger entries; range 0 to DEPTH-1.
REQ-004 SHALL provide port clock, input, 1, single clock; all logic on its rising edge.
REQ-005 SHALL provide port reset, input, 1, synchronous, active-high.
REQ-006 SHALL provide port sample_valid, input, 1, qualifies sample_data this cycle.
REQ-007 SHALL provide port sample_data, input, DATA_W, observed value (e.g. core test_value).
REQ-008 SHALL provide port arm, input, 1, single-cycle start-capture pulse.
REQ-009 SHALL provide ports trig_value and trig_mask, input, DATA_W each, trigger pattern and care-bits.
REQ-010 SHALL provide port rd_req, input, 1, read-one-entry request.
REQ-011 SHALL provide port rd_valid, output, 1, rd_data valid this cycle.
REQ-012 SHALL provide port rd_data, output, DATA_W, entry read out.
REQ-013 SHALL provide port state, output, 2: IDLE=0, ARMED=1, POST=2, DONE=3.
REQ-014 SHALL provide port count, output, log2(DEPTH)+1, entries held and not yet read.

Function
REQ-015 SHALL write sample_data at wr_ptr in ARMED and POST when sample_valid=1; wr_ptr SHALL wrap from DEPTH-1 to 0; all other states SHALL discard samples.
REQ-016 SHALL keep fill count saturating at DEPTH; count SHALL equal fill in ARMED, POST and DONE until reads begin.
REQ-017 SHALL treat a sample as a match when ((sample_data XOR trig_value) AND trig_mask) == 0; a mask of 0 SHALL match any valid sample.
REQ-018 SHALL trigger in ARMED only on a matching valid sample with pre-write fill >= PRE_TRIG; the triggering sample SHALL be stored.
REQ-019 SHALL ignore matches that occur while fill < PRE_TRIG.
REQ-020 SHALL transition IDLE->ARMED on arm, clearing wr_ptr, fill and read state.
REQ-021 SHALL transition ARMED->POST on trigger with post counter = DEPTH-PRE_TRIG-1; if that value is 0, SHALL transition ARMED->DONE directly.
REQ-022 SHALL decrement the post counter on each valid sample stored in POST, and SHALL enter DONE on the write that takes it to 0.
REQ-023 SHALL set the read pointer on DONE entry to the oldest entry, (wr_ptr - fill) mod DEPTH.
REQ-024 In DONE with count > 0, rd_req SHALL produce rd_valid=1 with the next entry, oldest first, on the following cycle, and count SHALL decrement by 1.
REQ-025 SHALL ignore rd_req when count == 0, with rd_valid held at 0; rd_valid SHALL be a 1-cycle pulse per accepted request.
REQ-026 SHALL ignore arm in ARMED and POST; arm in DONE SHALL restart as IDLE->ARMED does.
REQ-027 If arm and rd_req arrive together in DONE, arm SHALL win and the read SHALL be dropped.
REQ-028 SHALL ignore rd_req outside DONE.

Reset
REQ-029 SHALL on reset=1 force state=IDLE, rd_valid=0, rd_data=0, count=0, and clear wr_ptr, the read pointer, fill and the post counter; buffer contents need not clear.
REQ-030 SHALL let reset override every input, including mid-capture and mid-readout; the first cycle after reset SHALL be IDLE.

Configuration
REQ-031 With macro TRACE_TIMESTAMP_EN defined, SHALL add a 16-bit free-running cycle counter (reset 0, wraps) and a port rd_ts (output, 16) carrying each entry's capture cycle, aligned with rd_data.
REQ-032 Without TRACE_TIMESTAMP_EN, SHALL have no counter, no timestamp storage and no rd_ts port; all other behaviour SHALL be identical.

Verification (DATA_W=16, DEPTH=8, PRE_TRIG=3)
REQ-033 arm, then samples 0x0001..0x0009 one per cycle, trig_value=0x0005, trig_mask=0xFFFF -> trigger at 0x0005, DONE after 0x0009, count=8; 8 rd_req -> rd_data 0x0002..0x0009 in order, then count=0.
REQ-034 trig_value=0x0001, mask 0xFFFF, samples 0x0001,2,3,0x0001,... -> first match ignored (fill=0), trigger on the second 0x0001 (fill=3).
REQ-035 trig_mask=0x0000 and PRE_TRIG=7 -> trigger on the 8th sample, direct ARMED->DONE, count=8.
REQ-036 reset asserted during POST -> next cycle state=IDLE, count=0, rd_valid=0; following rd_req produces no rd_valid.
REQ-037 arm and rd_req together in DONE -> state=ARMED, no rd_valid, count=0.
REQ-038 With TRACE_TIMESTAMP_EN, samples on cycles 10..17 -> rd_ts increases by 1 per entry, matching each entry's capture cycle.

Source files
------------

// File: rtl/debug_trace_buffer.sv
// debug_trace_buffer: triggered circular trace capture with oldest-first readout.
// Optional feature macro TRACE_TIMESTAMP_EN adds a 16-bit cycle counter and an rd_ts port.
module debug_trace_buffer #(
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 64,
    parameter int PRE_TRIG = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     sample_valid,
    input  logic [DATA_W-1:0]        sample_data,
    input  logic                     arm,
    input  logic [DATA_W-1:0]        trig_value,
    input  logic [DATA_W-1:0]        trig_mask,
    input  logic                     rd_req,
    output logic                     rd_valid,
    output logic [DATA_W-1:0]        rd_data,
`ifdef TRACE_TIMESTAMP_EN
    output logic [15:0]              rd_ts,
`endif
    output logic [1:0]               state,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] POST_INIT = AW'(DEPTH - PRE_TRIG - 1);
    localparam logic [AW:0]   FULL      = (AW+1)'(DEPTH);
    localparam logic [AW:0]   PRE_FILL  = (AW+1)'(PRE_TRIG);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [AW:0]         fill_q, fill_d;
    logic [AW-1:0]       post_q, post_d;
    logic                rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                wr_en;
    logic                match;
    logic [AW:0]         fill_inc;
    logic [DATA_W-1:0]   mem [DEPTH];

`ifdef TRACE_TIMESTAMP_EN
    logic [15:0]         ts_q, ts_d;
    logic [15:0]         rd_ts_q, rd_ts_d;
    logic [15:0]         ts_mem [DEPTH];
`endif

    // Next-state, pointer, fill and readout logic.
    // fill doubles as the unread-entry count: it grows while capturing and shrinks on reads.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fill_d     = fill_q;
        post_d     = post_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        wr_en      = 1'b0;
        match      = ((sample_data ^ trig_value) & trig_mask) == '0;
        fill_inc   = (fill_q == FULL) ? fill_q : fill_q + 1'b1;
`ifdef TRACE_TIMESTAMP_EN
        ts_d       = ts_q + 16'd1;
        rd_ts_d    = rd_ts_q;
`endif
        case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d  = ARMED;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    fill_d   = '0;
                    post_d   = '0;
                end
            end
            ARMED: begin
                if (sample_valid) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    fill_d   = fill_inc;
                    if (match && (fill_q >= PRE_FILL)) begin
                        post_d  = POST_INIT;
                        state_d = (POST_INIT == '0) ? DONE : POST;
                    end
                end
            end
            POST: begin
                if (sample_valid) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    fill_d   = fill_inc;
                    post_d   = post_q - 1'b1;
                    if (post_q == AW'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (arm) begin
                    state_d  = ARMED;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    fill_d   = '0;
                    post_d   = '0;
                end else if (rd_req && (fill_q != '0)) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = mem[rd_ptr_q];
                    rd_ptr_d   = rd_ptr_q + 1'b1;
                    fill_d     = fill_q - 1'b1;
`ifdef TRACE_TIMESTAMP_EN
                    rd_ts_d    = ts_mem[rd_ptr_q];
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        // Oldest entry is computed from the post-write pointer and fill; a full buffer gives rd_ptr = wr_ptr.
        if ((state_q != DONE) && (state_d == DONE)) begin
            rd_ptr_d = wr_ptr_d - fill_d[AW-1:0];
        end
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            post_q     <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
`ifdef TRACE_TIMESTAMP_EN
            ts_q       <= '0;
            rd_ts_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
            post_q     <= post_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
`ifdef TRACE_TIMESTAMP_EN
            ts_q       <= ts_d;
            rd_ts_q    <= rd_ts_d;
`endif
        end
    end

    // Trace storage; contents are not reset.
    always_ff @(posedge clock) begin
        if (wr_en && !reset) begin
            mem[wr_ptr_q] <= sample_data;
`ifdef TRACE_TIMESTAMP_EN
            ts_mem[wr_ptr_q] <= ts_q;
`endif
        end
    end

    assign state    = state_q;
    assign count    = fill_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
`ifdef TRACE_TIMESTAMP_EN
    assign rd_ts    = rd_ts_q;
`endif

endmodule

// File: tb/tb_debug_trace_buffer.sv
// Bench for debug_trace_buffer: two instances (PRE_TRIG=3 and 7, DEPTH=8) share stimulus
// and are compared every cycle against a queue-based model; directed scenarios add literal checks.
module tb_debug_trace_buffer;

    localparam int DEPTH = 8;
    localparam int PRE0  = 3;
    localparam int PRE1  = 7;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, sample_valid, arm, rd_req;
    logic [15:0] sample_data, trig_value, trig_mask;

    logic        rv  [2];
    logic [15:0] rd  [2];
    logic [1:0]  st  [2];
    logic [3:0]  cnt [2];
`ifdef TRACE_TIMESTAMP_EN
    logic [15:0] ts  [2];
`endif

    debug_trace_buffer #(.DATA_W(16), .DEPTH(DEPTH), .PRE_TRIG(PRE0)) dut0 (
        .clock(clk), .reset(reset), .sample_valid(sample_valid), .sample_data(sample_data),
        .arm(arm), .trig_value(trig_value), .trig_mask(trig_mask), .rd_req(rd_req),
        .rd_valid(rv[0]), .rd_data(rd[0]),
`ifdef TRACE_TIMESTAMP_EN
        .rd_ts(ts[0]),
`endif
        .state(st[0]), .count(cnt[0])
    );

    debug_trace_buffer #(.DATA_W(16), .DEPTH(DEPTH), .PRE_TRIG(PRE1)) dut1 (
        .clock(clk), .reset(reset), .sample_valid(sample_valid), .sample_data(sample_data),
        .arm(arm), .trig_value(trig_value), .trig_mask(trig_mask), .rd_req(rd_req),
        .rd_valid(rv[1]), .rd_data(rd[1]),
`ifdef TRACE_TIMESTAMP_EN
        .rd_ts(ts[1]),
`endif
        .state(st[1]), .count(cnt[1])
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit started = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase per instance, a queue of the last DEPTH stored {timestamp, sample}.
    int          m_st  [2];
    int          m_rem [2];
    logic [31:0] mq    [2][$];
    logic        m_rv  [2];
    logic [15:0] m_rd  [2];
    logic [15:0] m_ts  [2];
    logic [15:0] m_cyc = 16'd0;

    function automatic int pre_of(input int k);
        return (k == 0) ? PRE0 : PRE1;
    endfunction

    task automatic store(input int k);
        mq[k].push_back({m_cyc, sample_data});
        if (mq[k].size() > DEPTH) void'(mq[k].pop_front());
    endtask

    task automatic model_step(input int k);
        logic [31:0] e;
        bit hit;
        if (reset) begin
            m_st[k] = 0; mq[k].delete(); m_rv[k] = 1'b0; m_rd[k] = 16'd0; m_ts[k] = 16'd0; m_rem[k] = 0;
            return;
        end
        m_rv[k] = 1'b0;
        case (m_st[k])
            0: if (arm) begin m_st[k] = 1; mq[k].delete(); end
            1: if (sample_valid) begin
                hit = (((sample_data ^ trig_value) & trig_mask) == 16'd0) && (mq[k].size() >= pre_of(k));
                store(k);
                if (hit) begin
                    m_rem[k] = DEPTH - pre_of(k) - 1;
                    m_st[k]  = (m_rem[k] == 0) ? 3 : 2;
                end
            end
            2: if (sample_valid) begin
                store(k);
                m_rem[k]--;
                if (m_rem[k] == 0) m_st[k] = 3;
            end
            default: begin
                if (arm) begin
                    m_st[k] = 1; mq[k].delete();
                end else if (rd_req && mq[k].size() > 0) begin
                    e = mq[k].pop_front();
                    m_rv[k] = 1'b1; m_rd[k] = e[15:0]; m_ts[k] = e[31:16];
                end
            end
        endcase
    endtask

    // Advance the model on each rising edge using the inputs the DUT sampled.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) model_step(k);
        m_cyc = reset ? 16'd0 : m_cyc + 16'd1;
    end

    // Compare every output of both instances against the model each cycle.
    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("state%0d", k), 32'(st[k]), 32'(m_st[k]));
                check($sformatf("count%0d", k), 32'(cnt[k]), 32'(mq[k].size()));
                check($sformatf("rd_valid%0d", k), 32'(rv[k]), 32'(m_rv[k]));
                check($sformatf("rd_data%0d", k), 32'(rd[k]), 32'(m_rd[k]));
`ifdef TRACE_TIMESTAMP_EN
                if (m_rv[k]) check($sformatf("rd_ts%0d", k), 32'(ts[k]), 32'(m_ts[k]));
`endif
            end
        end
    end

    // Drive one cycle of inputs, then wait until the following falling edge.
    task automatic step(input logic v, input logic [15:0] d, input logic a, input logic r);
        sample_valid = v; sample_data = d; arm = a; rd_req = r;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 16'd0, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; sample_valid = 1'b0; sample_data = '0; arm = 1'b0; rd_req = 1'b0;
        trig_value = '0; trig_mask = '0;
        @(negedge clk);
        started = 1'b1;
        step(1'b0, 16'd0, 1'b0, 1'b0);
        check("reset_state", 32'(st[0]), 32'd0);
        check("reset_count", 32'(cnt[0]), 32'd0);
        check("reset_rd_data", 32'(rd[0]), 32'd0);
        reset = 1'b0;

        // Basic capture: trigger at 5, done after 9, read 2..9.
        trig_value = 16'h0005; trig_mask = 16'hFFFF;
        step(1'b0, 16'd0, 1'b1, 1'b0);
        check("arm_state", 32'(st[0]), 32'd1);
        for (int i = 1; i <= 9; i++) begin
            step(1'b1, 16'(i), 1'b0, 1'b0);
            if (i == 4) check("pre_trig_armed", 32'(st[0]), 32'd1);
            if (i == 5) check("trig_post", 32'(st[0]), 32'd2);
        end
        check("capture_done", 32'(st[0]), 32'd3);
        check("capture_count", 32'(cnt[0]), 32'd8);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 16'd0, 1'b0, 1'b1);
            check("read_valid", 32'(rv[0]), 32'd1);
            check("read_data", 32'(rd[0]), 32'(i + 2));
        end
        check("drained_count", 32'(cnt[0]), 32'd0);
        step(1'b0, 16'd0, 1'b0, 1'b1);
        check("empty_read_ignored", 32'(rv[0]), 32'd0);

        // Mask 0 with PRE_TRIG=7: direct ARMED->DONE on the 8th sample.
        do_reset();
        trig_mask = 16'h0000;
        step(1'b0, 16'd0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 16'(16'h0010 + i), 1'b0, 1'b0);
            if (i == 6) check("mask0_still_armed", 32'(st[1]), 32'd1);
        end
        check("mask0_done", 32'(st[1]), 32'd3);
        check("mask0_count", 32'(cnt[1]), 32'd8);
        step(1'b0, 16'd0, 1'b0, 1'b1);
        check("mask0_oldest", 32'(rd[1]), 32'h0010);

        // Early match ignored while fill < PRE_TRIG.
        do_reset();
        trig_value = 16'h0001; trig_mask = 16'hFFFF;
        step(1'b0, 16'd0, 1'b1, 1'b0);
        step(1'b1, 16'h0001, 1'b0, 1'b0);
        step(1'b1, 16'h0002, 1'b0, 1'b0);
        step(1'b1, 16'h0003, 1'b0, 1'b0);
        check("early_match_ignored", 32'(st[0]), 32'd1);
        step(1'b1, 16'h0001, 1'b0, 1'b0);
        check("second_match_trig", 32'(st[0]), 32'd2);

        // Reset mid-POST.
        reset = 1'b1;
        step(1'b1, 16'h0007, 1'b0, 1'b1);
        reset = 1'b0;
        check("midpost_reset_state", 32'(st[0]), 32'd0);
        check("midpost_reset_count", 32'(cnt[0]), 32'd0);
        check("midpost_reset_rv", 32'(rv[0]), 32'd0);
        step(1'b0, 16'd0, 1'b0, 1'b1);
        check("idle_read_ignored", 32'(rv[0]), 32'd0);

        // arm + rd_req together in DONE: arm wins.
        trig_mask = 16'h0000;
        step(1'b0, 16'd0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 16'(16'h0100 + i), 1'b0, 1'b0);
        check("done_before_rearm", 32'(st[0]), 32'd3);
        step(1'b0, 16'd0, 1'b1, 1'b1);
        check("rearm_state", 32'(st[0]), 32'd1);
        check("rearm_rv", 32'(rv[0]), 32'd0);
        check("rearm_count", 32'(cnt[0]), 32'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            reset      = ($urandom_range(0, 299) == 0);
            trig_value = 16'($urandom_range(0, 7));
            trig_mask  = ($urandom_range(0, 9) == 0) ? 16'h0000 : 16'($urandom_range(0, 7));
            step($urandom_range(0, 4) != 0, 16'($urandom_range(0, 7)),
                 $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1);
        end
        reset = 1'b0;
        step(1'b0, 16'd0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
